parallel_elementwise_mac_seq: RTL
=================================

PARALLEL_ELEMENTWISE_MAC_SEQ -- requirements
Module: parallel_elementwise_mac_seq

Interface
REQ-001 SHALL have parameter N, default 8: bits per input integer.
REQ-002 SHALL have parameter L, default 8: elements per vector.
REQ-003 SHALL have parameter M, default 2: independent channels (vector pairs).
REQ-004 SHALL have parameter P, default 2: multipliers per channel; elements processed per beat.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  request to load one operand set.
REQ-008 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-009 SHALL have port mode  input  1  0 = elementwise only, 1 = elementwise plus per-channel dot product.
REQ-010 SHALL have port a  input  M*L*N  operand A; channel i, element j at bits [(i*L+j)*N +: N].
REQ-011 SHALL have port b  input  M*L*N  operand B; same packing as a.
REQ-012 SHALL have port out_valid  output  1  result and dot valid and stable.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port result  output  M*L*2N  products; channel i, element j at bits [(i*L+j)*2N +: 2N].
REQ-015 SHALL have port dot  output  M*D, D = 2N+$clog2(L)  per-channel sum of products; channel i at [i*D +: D].
REQ-016 SHALL have port busy  output  1  high in COMPUTE or DONE.

Function
REQ-017 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-018 SHALL drive in_ready high only in IDLE and not during reset.
REQ-019 SHALL accept on the edge where in_valid and in_ready are both high: capture a, b and mode; clear beat counter and dot accumulators; go to COMPUTE.
REQ-020 SHALL ignore changes on a, b and mode after acceptance until the next accept.
REQ-021 SHALL, in each COMPUTE beat k (0..L/P-1), per channel, multiply elements k*P..k*P+P-1 and write the products into result.
REQ-022 SHALL, when the captured mode is 1, add the sum of the P products of that beat into the channel's dot accumulator; when mode is 0, hold dot at 0.
REQ-023 SHALL treat operands as unsigned, form full 2N-bit products and D-bit sums, and never truncate or wrap.
REQ-024 SHALL go to DONE on the edge completing beat L/P-1; out_valid rises exactly L/P edges after the accept edge.
REQ-025 SHALL hold out_valid high and result and dot constant in DONE until out_ready is high.
REQ-026 SHALL go to IDLE on the edge where out_valid and out_ready are both high; out_valid low the following cycle.
REQ-027 SHALL keep in_ready low in DONE and ignore in_valid there; the minimum accept-to-accept period is L/P+2 cycles.
REQ-028 SHALL keep result and dot holding their last values in IDLE until the next COMPUTE overwrites them.
REQ-029 SHALL process all M channels in parallel with no cross-channel interaction.
REQ-030 SHALL stop elaboration with an error unless M>=1, L>=1, 1<=P<=L and L%P==0.

Reset
REQ-031 SHALL, while rst is high at an edge, go to IDLE and clear the beat counter, out_valid, busy, result and dot to 0; in_ready is 0 while rst is high.
REQ-032 SHALL, on reset in COMPUTE or DONE, abort the operation with no out_valid pulse; in_ready is 1 in the first cycle after rst falls.

Verification (N=8, L=8, M=2, P=2 unless stated)
REQ-033 SHALL cover: reset, all a=3, b=5, mode 0 -> out_valid 4 edges after accept, every result element 15, dot all 0.
REQ-034 SHALL cover: all a=b=255, mode 1 -> every result element 65025, each dot 520200 (19 bits, no overflow).
REQ-035 SHALL cover: mode 1, ch0 a[j]=b[j]=j, ch1 a=1, b=2 -> dot ch0=140, ch1=16; result ch0 element 7=49.
REQ-036 SHALL cover: out_ready low 10 cycles in DONE with in_valid high and a/b toggling -> out_valid, result and dot stable, in_ready 0, no accept.
REQ-037 SHALL cover: rst pulsed after beat 2 -> out_valid 0, result and dot 0, busy 0, in_ready 1 after release, no stale output.
REQ-038 SHALL cover: P=8, in_valid and out_ready held high -> out_valid 1 edge after accept, accepts every 3 cycles.

Source files
------------

// File: rtl/parallel_elementwise_mac_seq.sv
// Sequential elementwise multiplier with optional per-channel dot product.
// M independent channels each own P multipliers; a captured pair of L-element
// vectors is swept P elements per beat, so one operation takes L/P compute beats.
module parallel_elementwise_mac_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned L = 8,
    parameter int unsigned M = 2,
    parameter int unsigned P = 2,
    localparam int unsigned D = 2 * N + $clog2(L)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [M*L*N-1:0] a,
    input  logic [M*L*N-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M*L*2*N-1:0] result,
    output logic [M*D-1:0]   dot,
    output logic             busy
);

    // Guard against a zero P so the beat count stays defined while the check below fires.
    localparam int unsigned Beats = (P == 0) ? 1 : L / P;
    localparam int unsigned BW    = (Beats > 1) ? $clog2(Beats) : 1;

    if (M < 1 || L < 1 || P < 1 || P > L || (L % P) != 0) begin : g_param_check
        $error("parallel_elementwise_mac_seq: need M>=1, L>=1, 1<=P<=L and L%%P==0");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDone
    } state_e;

    state_e                 state_q;
    logic [BW-1:0]          beat_q;
    logic [M*L*N-1:0]       a_q;
    logic [M*L*N-1:0]       b_q;
    logic                   mode_q;
    logic [M*L*2*N-1:0]     result_q;
    logic [M*D-1:0]         dot_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [N-1:0]           a_el [M][P];
    logic [N-1:0]           b_el [M][P];
    logic [2*N-1:0]         prod [M][P];
    logic [D-1:0]           beat_sum [M];

    // Accept only from idle and never while reset is asserted, so the first cycle
    // after reset release can already take an operand set.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign dot       = dot_q;

    // Products of the P elements selected by the current beat, and their per-channel sum.
    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            beat_sum[i] = '0;
            for (int p = 0; p < int'(P); p++) begin
                a_el[i][p] = a_q[(i * int'(L) + int'(beat_q) * int'(P) + p) * int'(N) +: N];
                b_el[i][p] = b_q[(i * int'(L) + int'(beat_q) * int'(P) + p) * int'(N) +: N];
                prod[i][p] = (2 * N)'(a_el[i][p]) * (2 * N)'(b_el[i][p]);
                beat_sum[i] = beat_sum[i] + D'(prod[i][p]);
            end
        end
    end

    // Control FSM with registered status outputs and the result/dot datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            result_q    <= '0;
            dot_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        beat_q  <= '0;
                        dot_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    for (int i = 0; i < int'(M); i++) begin
                        for (int p = 0; p < int'(P); p++) begin
                            result_q[(i * int'(L) + int'(beat_q) * int'(P) + p) * 2 * int'(N)
                                     +: 2 * N] <= prod[i][p];
                        end
                        // In mode 0 dot stays at the zero written on accept.
                        if (mode_q) begin
                            dot_q[i * int'(D) +: D] <= dot_q[i * int'(D) +: D] + beat_sum[i];
                        end
                    end
                    if (beat_q == BW'(Beats - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
